// File: rtl/miriscv_lsu_split.sv
// Load/store unit between the miriscv core and a DATA_W-wide data port.
// A misaligned access that crosses a bus word either becomes two memory beats or raises a fault.
module miriscv_lsu_split #(
    parameter int DATA_W        = 32,
    parameter bit MISALIGNED_EN = 1'b1
) (
    input  logic                clk_i,
    input  logic                arstn_i,
    input  logic                lsu_req_i,
    input  logic                lsu_we_i,
    input  logic [2:0]          lsu_size_i,
    input  logic [31:0]         lsu_addr_i,
    input  logic [DATA_W-1:0]   lsu_data_i,
    output logic [DATA_W-1:0]   lsu_data_o,
    output logic                core_stall_o,
    output logic                lsu_fault_o,
    output logic                data_req_o,
    output logic                data_we_o,
    output logic [DATA_W/8-1:0] data_be_o,
    output logic [31:0]         data_addr_o,
    output logic [DATA_W-1:0]   data_wdata_o,
    input  logic [DATA_W-1:0]   data_rdata_i,
    input  logic                mem_ready_i
);
    localparam int L     = DATA_W / 8;
    localparam int OFF_W = $clog2(L);

    typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [31:0]         addr_q, addr_d;
    logic [2:0]          size_q, size_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rbuf_q, rbuf_d;

    logic [OFF_W-1:0]    off_in, off_q;
    logic [OFF_W+2:0]    rot_sh;
    logic [DATA_W-1:0]   rot_data;
    logic                illegal_in, cross_in, cross_q;
    logic                fault, complete;

    // True when an access of the given size starting at byte offset off spills past the bus word.
    function automatic logic crosses(input logic [OFF_W-1:0] off, input logic [2:0] size);
        logic [4:0] last;
        last = 5'(off) + (5'd1 << size[1:0]);
        return last > 5'(L);
    endfunction

    assign off_in     = lsu_addr_i[OFF_W-1:0];
    assign off_q      = addr_q[OFF_W-1:0];
    assign cross_in   = crosses(off_in, lsu_size_i);
    assign cross_q    = crosses(off_q, size_q);
    assign illegal_in = (lsu_size_i == 3'd7) ||
                        ((DATA_W == 32) && ((lsu_size_i == 3'd3) || (lsu_size_i == 3'd6)));

    // Store data is rotated once at accept time so both beats drive the same word.
    assign rot_sh   = {off_in, 3'b000};
    assign rot_data = (lsu_data_i << rot_sh) | (lsu_data_i >> (DATA_W - int'(rot_sh)));

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        rbuf_d   = rbuf_q;
        fault    = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (lsu_req_i) begin
                    if (illegal_in || (cross_in && !MISALIGNED_EN)) begin
                        fault = 1'b1;
                    end else begin
                        addr_d  = lsu_addr_i;
                        size_d  = lsu_size_i;
                        we_d    = lsu_we_i;
                        wdata_d = rot_data;
                        state_d = BEAT0;
                    end
                end
            end
            BEAT0: begin
                if (mem_ready_i) begin
                    if (cross_q) begin
                        rbuf_d  = data_rdata_i;
                        state_d = BEAT1;
                    end else begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            BEAT1: begin
                if (mem_ready_i) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rbuf_q  <= rbuf_d;
        end
    end

    logic [2*L-1:0]    nmask, be_full;
    logic [31:0]       addr_aligned;

    always_comb begin
        nmask = '0;
        for (int i = 0; i < L; i++) begin
            nmask[i] = (i < (1 << size_q[1:0]));
        end
    end

    assign be_full      = nmask << off_q;
    assign addr_aligned = {addr_q[31:OFF_W], {OFF_W{1'b0}}};

    assign data_req_o   = (state_q == BEAT0) || (state_q == BEAT1);
    assign data_we_o    = data_req_o && we_q;
    assign data_be_o    = (state_q == BEAT0) ? be_full[L-1:0] :
                          (state_q == BEAT1) ? be_full[2*L-1:L] : '0;
    assign data_addr_o  = (state_q == BEAT0) ? addr_aligned :
                          (state_q == BEAT1) ? addr_aligned + 32'(L) : '0;
    assign data_wdata_o = data_req_o ? wdata_q : '0;

    // Reset must silence the request-derived outputs even while the core holds lsu_req_i.
    assign core_stall_o = arstn_i && lsu_req_i && !complete && !fault;
    assign lsu_fault_o  = arstn_i && fault;

    logic [2*DATA_W-1:0] ld_vec;
    logic [DATA_W-1:0]   ld_raw, ld_keep, ld_ext;
    logic                ld_sign;

    assign ld_vec = (state_q == BEAT1) ? {data_rdata_i, rbuf_q} : {{DATA_W{1'b0}}, data_rdata_i};

    always_comb begin
        ld_raw = DATA_W'(ld_vec >> {off_q, 3'b000});
        for (int i = 0; i < DATA_W; i++) begin
            ld_keep[i] = (i < (8 << size_q[1:0]));
        end
        case (size_q[1:0])
            2'd0:    ld_sign = ld_raw[7];
            2'd1:    ld_sign = ld_raw[15];
            2'd2:    ld_sign = ld_raw[31];
            default: ld_sign = ld_raw[DATA_W-1];
        endcase
        ld_ext = (ld_raw & ld_keep) | ((!size_q[2] && ld_sign) ? ~ld_keep : '0);
    end

    assign lsu_data_o = complete ? ld_ext : '0;

endmodule

// File: tb/tb_miriscv_lsu_split.sv
// Directed bench for miriscv_lsu_split: 32-bit split, 32-bit faulting and 64-bit instances.
module tb_miriscv_lsu_split;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        arstn;
    logic        req, we, ready;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [63:0] wdat, rdata;
    int          sel;

    logic req0, req1, req2, rdy0, rdy1, rdy2;
    assign req0 = req && (sel == 0);
    assign req1 = req && (sel == 1);
    assign req2 = req && (sel == 2);
    assign rdy0 = ready && (sel == 0);
    assign rdy1 = ready && (sel == 1);
    assign rdy2 = ready && (sel == 2);

    logic [31:0] a_ld, a_wd, a_addr, n_ld, n_wd, n_addr, w_addr;
    logic [3:0]  a_be, n_be;
    logic [7:0]  w_be;
    logic [63:0] w_ld, w_wd;
    logic        a_st, a_ft, a_rq, a_we, n_st, n_ft, n_rq, n_we, w_st, w_ft, w_rq, w_we;

    miriscv_lsu_split #(.DATA_W(32), .MISALIGNED_EN(1'b1)) u_split (
        .clk_i(clk), .arstn_i(arstn), .lsu_req_i(req0), .lsu_we_i(we), .lsu_size_i(size),
        .lsu_addr_i(addr), .lsu_data_i(wdat[31:0]), .lsu_data_o(a_ld), .core_stall_o(a_st),
        .lsu_fault_o(a_ft), .data_req_o(a_rq), .data_we_o(a_we), .data_be_o(a_be),
        .data_addr_o(a_addr), .data_wdata_o(a_wd), .data_rdata_i(rdata[31:0]), .mem_ready_i(rdy0));

    miriscv_lsu_split #(.DATA_W(32), .MISALIGNED_EN(1'b0)) u_nosplit (
        .clk_i(clk), .arstn_i(arstn), .lsu_req_i(req1), .lsu_we_i(we), .lsu_size_i(size),
        .lsu_addr_i(addr), .lsu_data_i(wdat[31:0]), .lsu_data_o(n_ld), .core_stall_o(n_st),
        .lsu_fault_o(n_ft), .data_req_o(n_rq), .data_we_o(n_we), .data_be_o(n_be),
        .data_addr_o(n_addr), .data_wdata_o(n_wd), .data_rdata_i(rdata[31:0]), .mem_ready_i(rdy1));

    miriscv_lsu_split #(.DATA_W(64), .MISALIGNED_EN(1'b1)) u_wide (
        .clk_i(clk), .arstn_i(arstn), .lsu_req_i(req2), .lsu_we_i(we), .lsu_size_i(size),
        .lsu_addr_i(addr), .lsu_data_i(wdat), .lsu_data_o(w_ld), .core_stall_o(w_st),
        .lsu_fault_o(w_ft), .data_req_o(w_rq), .data_we_o(w_we), .data_be_o(w_be),
        .data_addr_o(w_addr), .data_wdata_o(w_wd), .data_rdata_i(rdata), .mem_ready_i(rdy2));

    logic        o_stall, o_fault, o_req, o_we;
    logic [7:0]  o_be;
    logic [31:0] o_addr;
    logic [63:0] o_wdata, o_ldata;

    always_comb begin
        o_stall = w_st; o_fault = w_ft; o_req = w_rq; o_we = w_we;
        o_be = w_be; o_addr = w_addr; o_wdata = w_wd; o_ldata = w_ld;
        if (sel == 0) begin
            o_stall = a_st; o_fault = a_ft; o_req = a_rq; o_we = a_we;
            o_be = {4'h0, a_be}; o_addr = a_addr; o_wdata = {32'h0, a_wd}; o_ldata = {32'h0, a_ld};
        end else if (sel == 1) begin
            o_stall = n_st; o_fault = n_ft; o_req = n_rq; o_we = n_we;
            o_be = {4'h0, n_be}; o_addr = n_addr; o_wdata = {32'h0, n_wd}; o_ldata = {32'h0, n_ld};
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int          st_cnt, nb;
    logic        any_req, flt, fin;
    logic [63:0] res;
    logic [31:0] b_addr [2];
    logic [7:0]  b_be   [2];
    logic [63:0] b_wd   [2];
    logic        b_we   [2];

    // One core access against a simple memory that answers after wt wait cycles per beat.
    task automatic do_access(input int s, input logic [2:0] sz, input logic w, input logic [31:0] a,
                             input logic [63:0] d, input logic [63:0] r0, input logic [63:0] r1,
                             input int wt);
        logic [31:0] base;
        int          wc;
        base = (s == 2) ? (a & ~32'h7) : (a & ~32'h3);
        @(posedge clk); #1;
        sel = s; req = 1'b1; we = w; size = sz; addr = a; wdat = d; ready = 1'b0; rdata = '0;
        st_cnt = 0; nb = 0; any_req = 1'b0; res = '0; flt = 1'b0; fin = 1'b0; wc = 0;
        for (int c = 0; c < 40 && !fin; c++) begin
            @(negedge clk);
            if (o_req) any_req = 1'b1;
            if (o_req && ready && nb < 2) begin
                b_addr[nb] = o_addr; b_be[nb] = o_be; b_wd[nb] = o_wdata; b_we[nb] = o_we;
                nb++;
            end
            if (o_stall) st_cnt++;
            else begin
                fin = 1'b1; res = o_ldata; flt = o_fault;
            end
            if (!fin) begin
                @(posedge clk); #1;
                if (o_req) begin
                    rdata = (o_addr == base) ? r0 : r1;
                    ready = (wc == wt);
                    wc    = ready ? 0 : wc + 1;
                end else begin
                    ready = 1'b0;
                end
            end
        end
        check("access_done", {63'h0, fin}, 64'h1);
        $display("[TB] dut=%0d size=%0d we=%0d addr=%h stalls=%0d beats=%0d fault=%0d ldata=%h",
                 s, sz, w, a, st_cnt, nb, flt, res);
        @(posedge clk); #1;
        req = 1'b0; ready = 1'b0;
    endtask

    initial begin
        arstn = 1'b0; req = 1'b0; we = 1'b0; size = '0; addr = '0; wdat = '0;
        rdata = '0; ready = 1'b0; sel = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        req = 1'b1; #1;
        check("rst_stall", {63'h0, o_stall}, 64'h0);
        check("rst_req", {63'h0, o_req}, 64'h0);
        check("rst_be", {56'h0, o_be}, 64'h0);
        req = 1'b0;
        arstn = 1'b1;

        // LW aligned
        do_access(0, 3'd2, 1'b0, 32'h100, 64'h0, 64'hDEADBEEF, 64'h0, 0);
        check("lw_stall", 64'(st_cnt), 64'd1);
        check("lw_beats", 64'(nb), 64'd1);
        check("lw_be", {56'h0, b_be[0]}, 64'h0F);
        check("lw_addr", {32'h0, b_addr[0]}, 64'h100);
        check("lw_data", res, 64'hDEADBEEF);

        // LB / LBU top lane
        do_access(0, 3'd0, 1'b0, 32'h103, 64'h0, 64'h80123456, 64'h0, 0);
        check("lb_be", {56'h0, b_be[0]}, 64'h08);
        check("lb_data", res, 64'hFFFFFF80);
        do_access(0, 3'd4, 1'b0, 32'h103, 64'h0, 64'h80123456, 64'h0, 0);
        check("lbu_data", res, 64'h00000080);

        // SW split
        do_access(0, 3'd2, 1'b1, 32'h102, 64'h11223344, 64'h0, 64'h0, 0);
        check("sw_stall", 64'(st_cnt), 64'd2);
        check("sw_beats", 64'(nb), 64'd2);
        check("sw_b0_addr", {32'h0, b_addr[0]}, 64'h100);
        check("sw_b0_be", {56'h0, b_be[0]}, 64'h0C);
        check("sw_b0_wd", b_wd[0], 64'h33441122);
        check("sw_b0_we", {63'h0, b_we[0]}, 64'h1);
        check("sw_b1_addr", {32'h0, b_addr[1]}, 64'h104);
        check("sw_b1_be", {56'h0, b_be[1]}, 64'h03);
        check("sw_b1_wd", b_wd[1], 64'h33441122);

        // LH split with 2 wait cycles per beat
        do_access(0, 3'd1, 1'b0, 32'h103, 64'h0, 64'hAB000000, 64'h000000CD, 2);
        check("lh_split_stall", 64'(st_cnt), 64'd6);
        check("lh_split_data", res, 64'hFFFFCDAB);
        check("lh_split_b1_be", {56'h0, b_be[1]}, 64'h01);

        // Faulting instance
        do_access(1, 3'd2, 1'b0, 32'h101, 64'h0, 64'h0, 64'h0, 0);
        check("mis_fault", {63'h0, flt}, 64'h1);
        check("mis_stall", 64'(st_cnt), 64'd0);
        check("mis_noreq", {63'h0, any_req}, 64'h0);
        do_access(1, 3'd3, 1'b0, 32'h100, 64'h0, 64'h0, 64'h0, 0);
        check("size3_fault", {63'h0, flt}, 64'h1);
        do_access(1, 3'd2, 1'b0, 32'h100, 64'h0, 64'h12345678, 64'h0, 0);
        check("nosplit_lw_fault", {63'h0, flt}, 64'h0);
        check("nosplit_lw_data", res, 64'h12345678);

        // 64-bit: LW/LWU in the upper half
        do_access(2, 3'd2, 1'b0, 32'h14, 64'h0, 64'h87654321_00000000, 64'h0, 0);
        check("w64_lw_be", {56'h0, b_be[0]}, 64'hF0);
        check("w64_lw_data", res, 64'hFFFFFFFF_87654321);
        do_access(2, 3'd6, 1'b0, 32'h14, 64'h0, 64'h87654321_00000000, 64'h0, 0);
        check("w64_lwu_data", res, 64'h00000000_87654321);

        // 64-bit: LD interrupted by reset in BEAT0
        @(posedge clk); #1;
        sel = 2; req = 1'b1; we = 1'b0; size = 3'd3; addr = 32'h10; ready = 1'b0;
        @(negedge clk);
        check("ld_req_stall", {63'h0, o_stall}, 64'h1);
        @(negedge clk);
        check("ld_beat0_req", {63'h0, o_req}, 64'h1);
        check("ld_beat0_be", {56'h0, o_be}, 64'hFF);
        #1 arstn = 1'b0;
        #1;
        check("ld_rst_req", {63'h0, o_req}, 64'h0);
        check("ld_rst_stall", {63'h0, o_stall}, 64'h0);
        check("ld_rst_be", {56'h0, o_be}, 64'h0);
        check("ld_rst_addr", {32'h0, o_addr}, 64'h0);
        check("ld_rst_misc", {o_wdata | o_ldata}, 64'h0);
        check("ld_rst_we_fault", {62'h0, o_we, o_fault}, 64'h0);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        arstn = 1'b1;
        do_access(2, 3'd3, 1'b0, 32'h10, 64'h0, 64'h01234567_89ABCDEF, 64'h0, 1);
        check("ld_again_stall", 64'(st_cnt), 64'd2);
        check("ld_again_addr", {32'h0, b_addr[0]}, 64'h10);
        check("ld_again_data", res, 64'h01234567_89ABCDEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
